mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit.sv | 286 ++++++++++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//
// Load/store unit between the decode/execute control path and a simple
// request/grant data bus. Each access is checked for legality, presented to
// the bus as a word-aligned request with byte enables and lane-replicated
// store data, and, for loads, the returned word is narrowed and extended.
// A per-access cycle budget turns a bus that never answers into a fault.
//
// Parameters
//   TIMEOUT_CYCLES  cycles allowed in REQ plus WAIT before the access faults
//
// Ports
//   clk_i, rst_i                 clock, synchronous active-high reset
//   MemRead_i, MemWrite_i        load / store request from decode
//   funct3_i                     access size and sign
//   addr_i, wdata_i              byte address and store data (rs2)
//   flush_i                      abandon an access that has not been granted
//   bus_req_o, bus_we_o          bus request and write strobe
//   bus_addr_o, bus_be_o         word-aligned address and byte enables
//   bus_wdata_o                  lane-aligned store data
//   bus_gnt_i, bus_rvalid_i      grant and read-data qualifier
//   bus_rdata_i                  read data word
//   stall_o                      hold the pipeline while the access runs
//   rdata_o, rdata_valid_o       extended load result and its qualifier
//   fault_o                      illegal or timed-out access
// -----------------------------------------------------------------------------
module mem_access_unit #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic        flush_i,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_be_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_gnt_i,
    input  logic        bus_rvalid_i,
    input  logic [31:0] bus_rdata_i,
    output logic        stall_o,
    output logic [31:0] rdata_o,
    output logic        rdata_valid_o,
    output logic        fault_o
);

    // The counter only has to reach TIMEOUT_CYCLES-1: the access leaves
    // REQ/WAIT in the cycle the counter shows that value.
    localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // -------------------------------------------------------------------------
    // Lane helpers
    // -------------------------------------------------------------------------
    function automatic logic [3:0] byte_enables(input logic [1:0] size,
                                                input logic [1:0] lane);
        case (size)
            2'b00:   byte_enables = 4'b0001 << lane;
            2'b01:   byte_enables = 4'b0011 << {lane[1], 1'b0};
            default: byte_enables = 4'b1111;
        endcase
    endfunction

    // Replicating the store data across lanes lets the bus pick any lane
    // with the byte enables alone.
    function automatic logic [31:0] store_lanes(input logic [1:0]  size,
                                                input logic [31:0] data);
        case (size)
            2'b00:   store_lanes = {4{data[7:0]}};
            2'b01:   store_lanes = {2{data[15:0]}};
            default: store_lanes = data;
        endcase
    endfunction

    function automatic logic [31:0] load_extend(input logic [2:0]  f3,
                                                input logic [1:0]  lane,
                                                input logic [31:0] word);
        logic [7:0]  sel_b;
        logic [15:0] sel_h;
        case (lane)
            2'd0:    sel_b = word[7:0];
            2'd1:    sel_b = word[15:8];
            2'd2:    sel_b = word[23:16];
            default: sel_b = word[31:24];
        endcase
        sel_h = lane[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  load_extend = {{24{sel_b[7]}}, sel_b};
            3'b001:  load_extend = {{16{sel_h[15]}}, sel_h};
            3'b100:  load_extend = {24'd0, sel_b};
            3'b101:  load_extend = {16'd0, sel_h};
            default: load_extend = word;
        endcase
    endfunction

    // -------------------------------------------------------------------------
    // Signals
    // -------------------------------------------------------------------------
    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] tmo_cnt_q;
    logic             tmo_flag_q;
    logic             load_flag_q;
    logic             tmo_hit;
    logic             load_resp;

    logic             access;
    logic             f3_ok;
    logic             misalign;
    logic             req_bad;
    logic             req_legal;
    logic             req_fault;

    logic [31:0]      addr_q;
    logic [2:0]       funct3_q;
    logic             we_q;
    logic [3:0]       be_q;
    logic [31:0]      wdata_q;
    logic [31:0]      rdata_q;

    // -------------------------------------------------------------------------
    // Request decode (only consumed in IDLE)
    // -------------------------------------------------------------------------
    always_comb begin
        access = MemRead_i | MemWrite_i;
        if (MemRead_i)
            f3_ok = funct3_i inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        else
            f3_ok = funct3_i inside {3'b000, 3'b001, 3'b010};
        misalign = ((funct3_i[1:0] == 2'b01) && addr_i[0]) ||
                   ((funct3_i[1:0] == 2'b10) && (addr_i[1:0] != 2'b00));
        req_bad   = (MemRead_i & MemWrite_i) | ~f3_ok | misalign;
        req_legal = access & ~req_bad;
        req_fault = access & req_bad;
    end

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            tmo_cnt_q   <= '0;
            tmo_flag_q  <= 1'b0;
            load_flag_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            tmo_flag_q  <= tmo_hit;
            load_flag_q <= load_resp;
            // Held at zero in IDLE so it is clear on entry to REQ, and runs
            // across REQ and WAIT so the budget covers the whole access.
            if (state_q == S_IDLE)
                tmo_cnt_q <= '0;
            else if ((state_q == S_REQ) || (state_q == S_WAIT))
                tmo_cnt_q <= tmo_cnt_q + 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next state
    // -------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        tmo_hit   = 1'b0;
        load_resp = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_legal)
                    state_d = S_REQ;
            end
            S_REQ: begin
                // A grant beats both a flush and the timeout in the same cycle.
                if (bus_gnt_i) begin
                    if (we_q) begin
                        state_d = S_DONE;
                    end else if (bus_rvalid_i) begin
                        state_d   = S_DONE;
                        load_resp = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                    end
                end else if (flush_i) begin
                    state_d = S_IDLE;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    state_d = S_DONE;
                    tmo_hit = 1'b1;
                end
            end
            S_WAIT: begin
                if (bus_rvalid_i) begin
                    state_d   = S_DONE;
                    load_resp = 1'b1;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    state_d = S_DONE;
                    tmo_hit = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Access and response registers
    // -------------------------------------------------------------------------
    // These are cleared by reset as well, so nothing from an abandoned access
    // is visible on the bus or result outputs afterwards.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            addr_q   <= '0;
            funct3_q <= '0;
            we_q     <= 1'b0;
            be_q     <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
        end else begin
            if ((state_q == S_IDLE) && req_legal) begin
                addr_q   <= addr_i;
                funct3_q <= funct3_i;
                we_q     <= MemWrite_i;
                be_q     <= byte_enables(funct3_i[1:0], addr_i[1:0]);
                wdata_q  <= store_lanes(funct3_i[1:0], wdata_i);
            end
            if (load_resp)
                rdata_q <= load_extend(funct3_q, addr_q[1:0], bus_rdata_i);
        end
    end

    // -------------------------------------------------------------------------
    // FSM: outputs
    // -------------------------------------------------------------------------
    // Everything is forced low while reset is held, including the first
    // cycle before the state register has seen a reset edge.
    always_comb begin
        bus_req_o     = 1'b0;
        bus_we_o      = 1'b0;
        bus_addr_o    = '0;
        bus_be_o      = '0;
        bus_wdata_o   = '0;
        stall_o       = 1'b0;
        rdata_o       = '0;
        rdata_valid_o = 1'b0;
        fault_o       = 1'b0;
        if (!rst_i) begin
            bus_addr_o  = {addr_q[31:2], 2'b00};
            bus_be_o    = be_q;
            bus_wdata_o = wdata_q;
            rdata_o     = rdata_q;
            case (state_q)
                S_IDLE: begin
                    // Stall is raised in the same cycle the access is seen so
                    // the pipeline does not move past it.
                    stall_o = req_legal;
                    fault_o = req_fault;
                end
                S_REQ: begin
                    stall_o   = 1'b1;
                    bus_req_o = 1'b1;
                    bus_we_o  = we_q;
                end
                S_WAIT: begin
                    stall_o = 1'b1;
                end
                default: begin
                    rdata_valid_o = load_flag_q;
                    fault_o       = tmo_flag_q;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// -----------------------------------------------------------------------------
// tb_mem_access_unit
//
// Table of single accesses (inputs, bus timing and expected bus/result
// values) applied in a loop, followed by hand-written sequences for flush,
// flush-with-grant and reset in the middle of an access. Load results are
// pushed to a queue when the access is issued and popped when rdata_valid_o
// is seen.
// -----------------------------------------------------------------------------
module tb_mem_access_unit;

    localparam int TMO = 4;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        MemRead_i;
    logic        MemWrite_i;
    logic [2:0]  funct3_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        flush_i;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [3:0]  bus_be_o;
    logic [31:0] bus_wdata_o;
    logic        bus_gnt_i;
    logic        bus_rvalid_i;
    logic [31:0] bus_rdata_i;
    logic        stall_o;
    logic [31:0] rdata_o;
    logic        rdata_valid_o;
    logic        fault_o;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q[$];

    always #5 clk_i = ~clk_i;

    mem_access_unit #(
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .MemRead_i     (MemRead_i),
        .MemWrite_i    (MemWrite_i),
        .funct3_i      (funct3_i),
        .addr_i        (addr_i),
        .wdata_i       (wdata_i),
        .flush_i       (flush_i),
        .bus_req_o     (bus_req_o),
        .bus_we_o      (bus_we_o),
        .bus_addr_o    (bus_addr_o),
        .bus_be_o      (bus_be_o),
        .bus_wdata_o   (bus_wdata_o),
        .bus_gnt_i     (bus_gnt_i),
        .bus_rvalid_i  (bus_rvalid_i),
        .bus_rdata_i   (bus_rdata_i),
        .stall_o       (stall_o),
        .rdata_o       (rdata_o),
        .rdata_valid_o (rdata_valid_o),
        .fault_o       (fault_o)
    );

    typedef enum int {O_FAULT, O_STORE, O_LOAD, O_TMO} outcome_t;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          gnt_dly;   // REQ cycles before the one carrying gnt
        int          rv_dly;    // 0: rvalid with gnt, n: rvalid in WAIT cycle n
        logic [31:0] word;
        outcome_t    outcome;
        logic [3:0]  be;
        logic [31:0] baddr;
        logic [31:0] bwdata;
        logic [31:0] rdata;
        int          req_cyc;
        int          stall_cyc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rd, input logic wr, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input int gnt_dly, input int rv_dly, input logic [31:0] word,
                                input outcome_t oc, input logic [3:0] be,
                                input logic [31:0] baddr, input logic [31:0] bwdata,
                                input logic [31:0] rdata, input int req_cyc, input int stall_cyc);
        vec_t v;
        v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = addr; v.wdata = wdata;
        v.gnt_dly = gnt_dly; v.rv_dly = rv_dly; v.word = word; v.outcome = oc;
        v.be = be; v.baddr = baddr; v.bwdata = bwdata; v.rdata = rdata;
        v.req_cyc = req_cyc; v.stall_cyc = stall_cyc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic pop_and_check(input string name);
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: rdata_valid_o with no load outstanding, rdata_o=0x%08h", name, rdata_o);
        end else begin
            chk(name, rdata_o, exp_q.pop_front());
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int    req_c;
        int    wait_c;
        int    stall_c;
        bit    seen_done;
        string tag;
        tag = $sformatf("v%0d", idx);
        MemRead_i  = v.rd;
        MemWrite_i = v.wr;
        funct3_i   = v.f3;
        addr_i     = v.addr;
        wdata_i    = v.wdata;
        @(negedge clk_i);
        chk1({tag, "_idle_stall"}, stall_o, v.outcome != O_FAULT);
        chk1({tag, "_idle_fault"}, fault_o, v.outcome == O_FAULT);
        chk1({tag, "_idle_req"}, bus_req_o, 1'b0);
        if (v.outcome == O_LOAD)
            exp_q.push_back(v.rdata);
        stall_c = stall_o ? 1 : 0;
        step();
        MemRead_i  = 1'b0;
        MemWrite_i = 1'b0;
        if (v.outcome == O_FAULT) begin
            repeat (2) begin
                @(negedge clk_i);
                chk1({tag, "_fault_noreq"}, bus_req_o, 1'b0);
                chk1({tag, "_fault_nostall"}, stall_o, 1'b0);
                chk1({tag, "_fault_pulse"}, fault_o, 1'b0);
            end
            step();
        end else begin
            req_c     = 0;
            wait_c    = 0;
            seen_done = 1'b0;
            for (int cyc = 0; cyc < 20 && !seen_done; cyc++) begin
                @(negedge clk_i);
                if (!stall_o) begin
                    seen_done = 1'b1;
                    chk1({tag, "_done_valid"}, rdata_valid_o, v.outcome == O_LOAD);
                    chk1({tag, "_done_fault"}, fault_o, v.outcome == O_TMO);
                    chk1({tag, "_done_req"}, bus_req_o, 1'b0);
                    if (rdata_valid_o)
                        pop_and_check({tag, "_rdata"});
                end else begin
                    stall_c++;
                    if (bus_req_o) begin
                        req_c++;
                        chk({tag, "_addr"}, bus_addr_o, v.baddr);
                        chk({tag, "_be"}, 32'(bus_be_o), 32'(v.be));
                        chk1({tag, "_we"}, bus_we_o, v.wr);
                        if (v.wr)
                            chk({tag, "_wdata"}, bus_wdata_o, v.bwdata);
                        if (req_c - 1 == v.gnt_dly) begin
                            bus_gnt_i = 1'b1;
                            if (v.rd && v.rv_dly == 0) begin
                                bus_rvalid_i = 1'b1;
                                bus_rdata_i  = v.word;
                            end
                        end
                    end else begin
                        wait_c++;
                        if (wait_c == v.rv_dly) begin
                            bus_rvalid_i = 1'b1;
                            bus_rdata_i  = v.word;
                        end
                    end
                end
                step();
                bus_gnt_i    = 1'b0;
                bus_rvalid_i = 1'b0;
                bus_rdata_i  = $urandom;
            end
            if (!seen_done) begin
                n_checks++;
                n_fail++;
                $display("FAIL %s_done: stall_o still high after 20 cycles", tag);
            end
            chk_int({tag, "_req_cycles"}, req_c, v.req_cyc);
            chk_int({tag, "_stall_cycles"}, stall_c, v.stall_cyc);
            @(negedge clk_i);
            chk1({tag, "_after_valid"}, rdata_valid_o, 1'b0);
            chk1({tag, "_after_stall"}, stall_o, 1'b0);
            chk1({tag, "_after_fault"}, fault_o, 1'b0);
            step();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        //          rd wr f3      addr          wdata         gnt rv  word          outcome  be       baddr         bwdata        rdata         req stall
        vecs.push_back(mk(1, 0, 3'b000, 32'h0000_0103, 32'h0,         0,  1,  32'h80FF_7F01, O_LOAD,  4'b1000, 32'h0000_0100, 32'h0,         32'hFFFF_FF80, 1, 3));
        vecs.push_back(mk(0, 1, 3'b001, 32'h0000_0202, 32'h0000_BEEF, 2,  0,  32'h0,         O_STORE, 4'b1100, 32'h0000_0200, 32'hBEEF_BEEF, 32'h0,         3, 4));
        vecs.push_back(mk(1, 0, 3'b010, 32'h0000_0301, 32'h0,         0,  0,  32'h0,         O_FAULT, 4'b0000, 32'h0,         32'h0,         32'h0,         0, 0));
        vecs.push_back(mk(1, 0, 3'b101, 32'h0000_0402, 32'h0,         0,  0,  32'h8001_0000, O_LOAD,  4'b1100, 32'h0000_0400, 32'h0,         32'h0000_8001, 1, 2));
        vecs.push_back(mk(1, 0, 3'b010, 32'h0000_03FC, 32'h0,         99, 0,  32'h0,         O_TMO,   4'b1111, 32'h0000_03FC, 32'h0,         32'h0,         4, 5));
        vecs.push_back(mk(0, 1, 3'b000, 32'h0000_0005, 32'h1234_56A5, 1,  0,  32'h0,         O_STORE, 4'b0010, 32'h0000_0004, 32'hA5A5_A5A5, 32'h0,         2, 3));
        // rvalid lands in the same cycle the budget runs out
        vecs.push_back(mk(1, 0, 3'b001, 32'h0000_0006, 32'h0,         0,  3,  32'h8765_4321, O_LOAD,  4'b1100, 32'h0000_0004, 32'h0,         32'hFFFF_8765, 1, 5));
        vecs.push_back(mk(1, 0, 3'b100, 32'h0000_0101, 32'h0,         0,  1,  32'h80FF_C301, O_LOAD,  4'b0010, 32'h0000_0100, 32'h0,         32'h0000_00C3, 1, 3));
        vecs.push_back(mk(1, 0, 3'b000, 32'h0000_0101, 32'h0,         0,  1,  32'h80FF_7F01, O_LOAD,  4'b0010, 32'h0000_0100, 32'h0,         32'h0000_007F, 1, 3));
        vecs.push_back(mk(0, 1, 3'b010, 32'h0000_0010, 32'hDEAD_BEEF, 0,  0,  32'h0,         O_STORE, 4'b1111, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0,         1, 2));
        vecs.push_back(mk(1, 0, 3'b011, 32'h0000_0000, 32'h0,         0,  0,  32'h0,         O_FAULT, 4'b0000, 32'h0,         32'h0,         32'h0,         0, 0));
        vecs.push_back(mk(1, 1, 3'b010, 32'h0000_0000, 32'h0,         0,  0,  32'h0,         O_FAULT, 4'b0000, 32'h0,         32'h0,         32'h0,         0, 0));
        vecs.push_back(mk(0, 1, 3'b001, 32'h0000_0201, 32'h0,         0,  0,  32'h0,         O_FAULT, 4'b0000, 32'h0,         32'h0,         32'h0,         0, 0));
        vecs.push_back(mk(0, 1, 3'b100, 32'h0000_0000, 32'h0,         0,  0,  32'h0,         O_FAULT, 4'b0000, 32'h0,         32'h0,         32'h0,         0, 0));
        vecs.push_back(mk(1, 0, 3'b010, 32'h0000_0020, 32'h0,         1,  1,  32'h1234_5678, O_LOAD,  4'b1111, 32'h0000_0020, 32'h0,         32'h1234_5678, 2, 4));
        vecs.push_back(mk(1, 0, 3'b010, 32'h0000_0040, 32'h0,         0,  99, 32'h0,         O_TMO,   4'b1111, 32'h0000_0040, 32'h0,         32'h0,         1, 5));
        vecs.push_back(mk(1, 0, 3'b001, 32'h0000_0000, 32'h0,         0,  0,  32'h0000_F00F, O_LOAD,  4'b0011, 32'h0000_0000, 32'h0,         32'hFFFF_F00F, 1, 2));
        vecs.push_back(mk(1, 0, 3'b101, 32'h0000_0000, 32'h0,         0,  0,  32'h1234_F00F, O_LOAD,  4'b0011, 32'h0000_0000, 32'h0,         32'h0000_F00F, 1, 2));
        vecs.push_back(mk(0, 1, 3'b000, 32'h0000_0003, 32'h0000_00C4, 0,  0,  32'h0,         O_STORE, 4'b1000, 32'h0000_0000, 32'hC4C4_C4C4, 32'h0,         1, 2));

        // Reset with a legal load presented: nothing may leak out.
        rst_i        = 1'b1;
        MemRead_i    = 1'b1;
        MemWrite_i   = 1'b0;
        funct3_i     = 3'b010;
        addr_i       = 32'h0000_0010;
        wdata_i      = 32'h0;
        flush_i      = 1'b0;
        bus_gnt_i    = 1'b0;
        bus_rvalid_i = 1'b0;
        bus_rdata_i  = 32'h0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        chk1("rst_stall", stall_o, 1'b0);
        chk1("rst_req", bus_req_o, 1'b0);
        chk1("rst_we", bus_we_o, 1'b0);
        chk1("rst_fault", fault_o, 1'b0);
        chk1("rst_valid", rdata_valid_o, 1'b0);
        chk("rst_addr", bus_addr_o, 32'h0);
        chk("rst_be", 32'(bus_be_o), 32'h0);
        chk("rst_wdata", bus_wdata_o, 32'h0);
        chk("rst_rdata", rdata_o, 32'h0);
        step();
        MemRead_i = 1'b0;
        rst_i     = 1'b0;
        step();

        for (int i = 0; i < vecs.size(); i++)
            run_vec(i, vecs[i]);

        // Flush in the second REQ cycle with no grant: back to IDLE, no DONE.
        MemRead_i = 1'b1;
        funct3_i  = 3'b010;
        addr_i    = 32'h0000_0080;
        @(negedge clk_i);
        chk1("flush_idle_stall", stall_o, 1'b1);
        step();
        MemRead_i = 1'b0;
        @(negedge clk_i);
        chk1("flush_req1", bus_req_o, 1'b1);
        step();
        flush_i = 1'b1;
        @(negedge clk_i);
        chk1("flush_req2", bus_req_o, 1'b1);
        step();
        flush_i = 1'b0;
        @(negedge clk_i);
        chk1("flush_out_req", bus_req_o, 1'b0);
        chk1("flush_out_stall", stall_o, 1'b0);
        chk1("flush_out_valid", rdata_valid_o, 1'b0);
        chk1("flush_out_fault", fault_o, 1'b0);
        step();
        @(negedge clk_i);
        chk1("flush_later_valid", rdata_valid_o, 1'b0);
        chk1("flush_later_stall", stall_o, 1'b0);
        step();

        // Flush alongside the grant, and held through WAIT: both ignored.
        MemRead_i = 1'b1;
        funct3_i  = 3'b010;
        addr_i    = 32'h0000_00C0;
        exp_q.push_back(32'hCAFE_F00D);
        @(negedge clk_i);
        step();
        MemRead_i = 1'b0;
        @(negedge clk_i);
        chk1("fgnt_req", bus_req_o, 1'b1);
        bus_gnt_i = 1'b1;
        flush_i   = 1'b1;
        step();
        bus_gnt_i = 1'b0;
        @(negedge clk_i);
        chk1("fgnt_wait_req", bus_req_o, 1'b0);
        chk1("fgnt_wait_stall1", stall_o, 1'b1);
        step();
        @(negedge clk_i);
        chk1("fgnt_wait_stall2", stall_o, 1'b1);
        bus_rvalid_i = 1'b1;
        bus_rdata_i  = 32'hCAFE_F00D;
        step();
        bus_rvalid_i = 1'b0;
        flush_i      = 1'b0;
        @(negedge clk_i);
        chk1("fgnt_done_valid", rdata_valid_o, 1'b1);
        chk1("fgnt_done_stall", stall_o, 1'b0);
        if (rdata_valid_o)
            pop_and_check("fgnt_rdata");
        step();

        // Reset while waiting for read data, then a stale rvalid in IDLE.
        MemRead_i = 1'b1;
        funct3_i  = 3'b010;
        addr_i    = 32'h0000_0100;
        @(negedge clk_i);
        step();
        MemRead_i = 1'b0;
        @(negedge clk_i);
        bus_gnt_i = 1'b1;
        step();
        bus_gnt_i = 1'b0;
        @(negedge clk_i);
        chk1("rstw_wait_stall", stall_o, 1'b1);
        rst_i = 1'b1;
        step();
        @(negedge clk_i);
        chk1("rstw_stall", stall_o, 1'b0);
        chk1("rstw_req", bus_req_o, 1'b0);
        chk("rstw_addr", bus_addr_o, 32'h0);
        chk("rstw_be", 32'(bus_be_o), 32'h0);
        chk("rstw_rdata", rdata_o, 32'h0);
        step();
        rst_i        = 1'b0;
        bus_rvalid_i = 1'b1;
        bus_rdata_i  = 32'hFFFF_FFFF;
        @(negedge clk_i);
        chk1("stale_valid1", rdata_valid_o, 1'b0);
        chk1("stale_stall", stall_o, 1'b0);
        chk1("stale_req", bus_req_o, 1'b0);
        step();
        bus_rvalid_i = 1'b0;
        @(negedge clk_i);
        chk1("stale_valid2", rdata_valid_o, 1'b0);
        chk("stale_rdata", rdata_o, 32'h0);
        step();

        chk_int("scoreboard_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
